sys_ctrl: RTL and testbench
===========================

# sys_ctrl

Command controller for the system's reference-clock domain. It decodes byte frames delivered by the UART receiver, sequences the register file and ALU, and pushes response bytes into the TX FIFO for the UART transmitter. It sits between the RX data synchronizer and the register file, ALU and async FIFO inside SYS_TOP.

## Interface

Parameters:

- WIDTH, 8, data byte width.
- no_of_addresses, 16, register file depth.
- address_bits, $clog2(no_of_addresses), register file address width.

Ports:

- REF_CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  WIDTH  received byte, valid when RX_D_VLD is high.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- RF_RD_DATA  in  WIDTH  register file read data.
- RF_RD_DATA_VLD  in  1  read data valid.
- ALU_OUT  in  2*WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- RF_ADDRESS  out  address_bits  register file address.
- RF_WR_EN  out  1  write strobe.
- RF_RD_EN  out  1  read strobe.
- RF_WR_DATA  out  WIDTH  write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function select.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  WIDTH  byte to TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.

## Operation

- Opcodes accepted in IDLE:
  - 0xAA is a write: addr, data.
  - 0xBB is a read: addr.
  - 0xCC is an ALU operation with operands: A, B, fun.
  - 0xDD is an ALU operation without operands: fun.
- Any other byte in IDLE is discarded; the FSM stays in IDLE.
- States:
  - IDLE.
  - WR_ADDR, WR_DATA.
  - RD_ADDR, RD_WAIT.
  - OP_A, OP_B, ALU_FUN_S, ALU_WAIT.
  - TX_BYTE0, TX_BYTE1.
- Write (0xAA):
  - IDLE→WR_ADDR.
  - Addr byte latched (low address_bits used, upper bits ignored) → WR_DATA.
  - Data byte → one-cycle RF_WR_EN with RF_ADDRESS/RF_WR_DATA → IDLE.
  - No response byte.
- Read (0xBB):
  - IDLE→RD_ADDR.
  - Addr byte → one-cycle RF_RD_EN → RD_WAIT.
  - On RF_RD_DATA_VLD, latch the data → TX_BYTE0 → IDLE.
  - Response: one byte.
- ALU with operands (0xCC):
  - Byte A → RF_WR_EN at address 0.
  - Byte B → RF_WR_EN at address 1.
  - Fun byte → ALU_FUN=fun[3:0], one-cycle ALU_EN → ALU_WAIT.
- ALU without operands (0xDD):
  - Fun byte → ALU_EN → ALU_WAIT, using the operands already stored at addresses 0/1.
- ALU_WAIT:
  - On ALU_OUT_VLD, latch the 16-bit result → TX_BYTE0 (ALU_OUT[7:0]) → TX_BYTE1 (ALU_OUT[15:8]) → IDLE.
  - Response: two bytes, low byte first.
- CLK_GATE_EN is high from entry to ALU_FUN_S (0xDD path) or OP_A (0xCC path) until leaving ALU_WAIT; low otherwise.
- TX states:
  - TX_D_VLD is pulsed for exactly one cycle per byte, only when FIFO_FULL=0.
  - While FIFO_FULL=1 the state holds and TX_P_DATA holds its value.
- RX_D_VLD pulses arriving in RD_WAIT, ALU_WAIT or TX states are dropped.
- Protocol errors are filtered upstream; the receiver never asserts RX_D_VLD for bad frames.

## Timing

- All outputs are registered.
- Reset values: all strobes are 0; RF_ADDRESS, RF_WR_DATA, ALU_FUN and TX_P_DATA are 0; CLK_GATE_EN is 0; state is IDLE.
- Reset assertion in any state returns to IDLE immediately (asynchronously) and aborts any partial frame.
- A byte sampled with RX_D_VLD at edge N produces its strobe (RF_WR_EN, RF_RD_EN or ALU_EN) high for cycle N+1 only.
- Read path: RF_RD_DATA_VLD is accepted from cycle N+2 onward. The FSM waits indefinitely for it.
- ALU path: the FSM waits indefinitely for ALU_OUT_VLD. The result is latched on the cycle ALU_OUT_VLD is high.
- TX byte: TX_D_VLD rises on the first edge after entering the TX state with FIFO_FULL=0. There is no gap cycle between TX_BYTE0 and TX_BYTE1 if the FIFO is not full.
- RX_D_VLD coincident with the IDLE return edge: the byte is treated as the next opcode only if the state is already IDLE on that edge; otherwise it is dropped.

## Test plan

- Write then read:
  - Stimulus: AA,0A,05 then BB,0A.
  - Response: RF_WR_EN one cycle with addr=0xA, data=0x05; then RF_RD_EN at addr 0xA.
  - With a model returning 0x05: a single TX_D_VLD with TX_P_DATA=0x05.
- ALU with operands:
  - Stimulus: CC,0A,0C,00.
  - Response: writes 0x0A→addr0 and 0x0C→addr1; ALU_EN with ALU_FUN=0; CLK_GATE_EN high through ALU_WAIT.
  - With ALU_OUT=0x0016: TX bytes 0x16 then 0x00.
- ALU without operands:
  - Stimulus: DD,06.
  - Response: no RF writes; ALU_EN with ALU_FUN=6.
  - With ALU_OUT=0xFFF7: TX bytes 0xF7 then 0xFF.
- Backpressure:
  - Stimulus: FIFO_FULL=1 during TX_BYTE0 for 10 cycles.
  - Response: no TX_D_VLD during those cycles and TX_P_DATA stable; after release, exactly two TX_D_VLD pulses.
- Junk opcode:
  - Stimulus: 0x55 then BB,03.
  - Response: 0x55 causes no activity; the read executes normally.
  - Stimulus: a byte in ALU_WAIT.
  - Response: the byte is ignored.
- Reset mid-frame:
  - Stimulus: AA,0A, then RST_N low for 1 cycle, then AA,04,07.
  - Response: no write to 0xA; a single write of 0x07 to address 4.
  - Outputs are at their reset values during reset.

Source files
------------

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes UART command frames, sequences register file and ALU accesses,
// and queues response bytes into the TX FIFO.
module sys_ctrl #(
    parameter int WIDTH           = 8,
    parameter int no_of_addresses = 16,
    parameter int address_bits    = $clog2(no_of_addresses)
) (
    input  logic                    REF_CLK,
    input  logic                    RST_N,
    input  logic [WIDTH-1:0]        RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [WIDTH-1:0]        RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*WIDTH-1:0]      ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [address_bits-1:0] RF_ADDRESS,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [WIDTH-1:0]        RF_WR_DATA,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [WIDTH-1:0]        TX_P_DATA,
    output logic                    TX_D_VLD
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_BYTE0, TX_BYTE1
    } state_t;

    state_t                  state, state_nx;
    logic [2*WIDTH-1:0]      res, res_nx;
    logic                    two, two_nx;
    logic [address_bits-1:0] addr_nx;
    logic [WIDTH-1:0]        wdata_nx, tx_nx;
    logic [3:0]              fun_nx;
    logic                    wr_nx, rd_nx, alu_nx, txv_nx;

    always_comb begin
        state_nx = state;
        res_nx   = res;
        two_nx   = two;
        addr_nx  = RF_ADDRESS;
        wdata_nx = RF_WR_DATA;
        fun_nx   = ALU_FUN;
        tx_nx    = TX_P_DATA;
        wr_nx    = 1'b0;
        rd_nx    = 1'b0;
        alu_nx   = 1'b0;
        txv_nx   = 1'b0;
        case (state)
            IDLE: if (RX_D_VLD)
                case (RX_P_DATA)
                    WIDTH'(8'hAA): state_nx = WR_ADDR;
                    WIDTH'(8'hBB): state_nx = RD_ADDR;
                    WIDTH'(8'hCC): state_nx = OP_A;
                    WIDTH'(8'hDD): state_nx = ALU_FUN_S;
                    default:       state_nx = IDLE;
                endcase
            WR_ADDR: if (RX_D_VLD) begin
                addr_nx  = RX_P_DATA[address_bits-1:0];
                state_nx = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wdata_nx = RX_P_DATA;
                wr_nx    = 1'b1;
                state_nx = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                addr_nx  = RX_P_DATA[address_bits-1:0];
                rd_nx    = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: if (RF_RD_DATA_VLD) begin
                res_nx   = {{WIDTH{1'b0}}, RF_RD_DATA};
                two_nx   = 1'b0;
                state_nx = TX_BYTE0;
            end
            OP_A: if (RX_D_VLD) begin
                addr_nx  = '0;
                wdata_nx = RX_P_DATA;
                wr_nx    = 1'b1;
                state_nx = OP_B;
            end
            OP_B: if (RX_D_VLD) begin
                addr_nx  = address_bits'(1);
                wdata_nx = RX_P_DATA;
                wr_nx    = 1'b1;
                state_nx = ALU_FUN_S;
            end
            ALU_FUN_S: if (RX_D_VLD) begin
                fun_nx   = RX_P_DATA[3:0];
                alu_nx   = 1'b1;
                state_nx = ALU_WAIT;
            end
            ALU_WAIT: if (ALU_OUT_VLD) begin
                res_nx   = ALU_OUT;
                two_nx   = 1'b1;
                state_nx = TX_BYTE0;
            end
            // TX_P_DATA only changes alongside its strobe, so it holds under backpressure
            TX_BYTE0: if (!FIFO_FULL) begin
                tx_nx    = res[WIDTH-1:0];
                txv_nx   = 1'b1;
                state_nx = two ? TX_BYTE1 : IDLE;
            end
            TX_BYTE1: if (!FIFO_FULL) begin
                tx_nx    = res[2*WIDTH-1:WIDTH];
                txv_nx   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            res         <= '0;
            two         <= 1'b0;
            RF_ADDRESS  <= '0;
            RF_WR_DATA  <= '0;
            ALU_FUN     <= '0;
            TX_P_DATA   <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            ALU_EN      <= 1'b0;
            TX_D_VLD    <= 1'b0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            state       <= state_nx;
            res         <= res_nx;
            two         <= two_nx;
            RF_ADDRESS  <= addr_nx;
            RF_WR_DATA  <= wdata_nx;
            ALU_FUN     <= fun_nx;
            TX_P_DATA   <= tx_nx;
            RF_WR_EN    <= wr_nx;
            RF_RD_EN    <= rd_nx;
            ALU_EN      <= alu_nx;
            TX_D_VLD    <= txv_nx;
            CLK_GATE_EN <= state_nx inside {OP_A, OP_B, ALU_FUN_S, ALU_WAIT};
        end
    end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed and randomized frames checked against a memory/ALU reference model.
module tb_sys_ctrl;
    logic        REF_CLK = 1'b0, RST_N = 1'b1;
    logic [7:0]  RX_P_DATA = '0, RF_RD_DATA = '0;
    logic        RX_D_VLD = 1'b0, RF_RD_DATA_VLD = 1'b0, ALU_OUT_VLD = 1'b0, FIFO_FULL = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic [3:0]  RF_ADDRESS, ALU_FUN;
    logic [7:0]  RF_WR_DATA, TX_P_DATA;
    logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    int          checks = 0, errors = 0;
    logic [7:0]  ref_mem [16];
    logic [7:0]  env_mem [16];

    sys_ctrl dut (
        .REF_CLK(REF_CLK), .RST_N(RST_N), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .RF_ADDRESS(RF_ADDRESS),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge REF_CLK);
    endtask

    // drive one byte for one cycle; returns at the negedge of the cycle its strobe is visible
    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge REF_CLK);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f[1:0])
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) - 16'(b);
            2'd2:    return 16'(a) * 16'(b);
            default: return {a, b};
        endcase
    endfunction

    task automatic chk_quiet(input string tag);
        chk(tag, 16'({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD}), 16'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, 16'({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN}), 16'd0);
        chk({tag, "_addr"}, 16'(RF_ADDRESS), 16'd0);
        chk({tag, "_wdata"}, 16'(RF_WR_DATA), 16'd0);
        chk({tag, "_fun"}, 16'(ALU_FUN), 16'd0);
        chk({tag, "_txdata"}, 16'(TX_P_DATA), 16'd0);
    endtask

    task automatic wr_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
        send(8'hAA);
        chk_quiet("wr_op_quiet");
        idle(gap);
        send(a);
        chk_quiet("wr_addr_quiet");
        idle(gap);
        send(d);
        chk("wr_en", 16'(RF_WR_EN), 16'd1);
        chk("wr_addr", 16'(RF_ADDRESS), 16'(a[3:0]));
        chk("wr_data", 16'(RF_WR_DATA), 16'(d));
        if (RF_WR_EN) env_mem[RF_ADDRESS] = RF_WR_DATA;
        ref_mem[a[3:0]] = d;
        @(negedge REF_CLK);
        chk("wr_en_one_cycle", 16'(RF_WR_EN), 16'd0);
    endtask

    task automatic rd_frame(input logic [7:0] a, input int gap, input int lat, input bit clash);
        logic [3:0] ra;
        send(8'hBB);
        chk_quiet("rd_op_quiet");
        idle(gap);
        send(a);
        chk("rd_en", 16'(RF_RD_EN), 16'd1);
        chk("rd_addr", 16'(RF_ADDRESS), 16'(a[3:0]));
        ra = RF_ADDRESS;
        @(negedge REF_CLK);
        chk("rd_en_one_cycle", 16'(RF_RD_EN), 16'd0);
        repeat (lat) begin
            chk("rd_wait_no_tx", 16'(TX_D_VLD), 16'd0);
            @(negedge REF_CLK);
        end
        RF_RD_DATA     = env_mem[ra];
        RF_RD_DATA_VLD = 1'b1;
        @(negedge REF_CLK);
        RF_RD_DATA_VLD = 1'b0;
        RF_RD_DATA     = 8'($urandom);
        chk("rd_tx_wait", 16'(TX_D_VLD), 16'd0);
        if (clash) send(8'hBB);
        else @(negedge REF_CLK);
        chk("rd_tx_vld", 16'(TX_D_VLD), 16'd1);
        chk("rd_tx_data", 16'(TX_P_DATA), 16'(ref_mem[a[3:0]]));
        @(negedge REF_CLK);
        chk("rd_tx_single", 16'(TX_D_VLD), 16'd0);
    endtask

    task automatic alu_frame(input bit ops, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                             input int gap, input int lat, input bit bp, input bit drop,
                             input bit ov_en, input logic [15:0] ov);
        logic [15:0] drive, exp;
        logic [7:0]  held;
        send(ops ? 8'hCC : 8'hDD);
        chk("cg_on_entry", 16'(CLK_GATE_EN), 16'd1);
        if (ops) begin
            idle(gap);
            send(a);
            chk("opa_wr", 16'(RF_WR_EN), 16'd1);
            chk("opa_addr", 16'(RF_ADDRESS), 16'd0);
            chk("opa_data", 16'(RF_WR_DATA), 16'(a));
            if (RF_WR_EN) env_mem[RF_ADDRESS] = RF_WR_DATA;
            ref_mem[0] = a;
            idle(gap);
            send(b);
            chk("opb_wr", 16'(RF_WR_EN), 16'd1);
            chk("opb_addr", 16'(RF_ADDRESS), 16'd1);
            chk("opb_data", 16'(RF_WR_DATA), 16'(b));
            if (RF_WR_EN) env_mem[RF_ADDRESS] = RF_WR_DATA;
            ref_mem[1] = b;
        end
        idle(gap);
        send(f);
        chk("alu_en", 16'(ALU_EN), 16'd1);
        chk("alu_fun", 16'(ALU_FUN), 16'(f[3:0]));
        chk("alu_no_wr", 16'(RF_WR_EN), 16'd0);
        @(negedge REF_CLK);
        chk("alu_en_one_cycle", 16'(ALU_EN), 16'd0);
        if (drop) begin
            send(8'hAA);
            chk_quiet("drop_quiet");
            chk("drop_cg", 16'(CLK_GATE_EN), 16'd1);
        end
        repeat (lat) begin
            chk("cg_in_wait", 16'(CLK_GATE_EN), 16'd1);
            @(negedge REF_CLK);
        end
        drive       = ov_en ? ov : alu(env_mem[0], env_mem[1], f[3:0]);
        exp         = ov_en ? ov : alu(ref_mem[0], ref_mem[1], f[3:0]);
        ALU_OUT     = drive;
        ALU_OUT_VLD = 1'b1;
        FIFO_FULL   = bp;
        @(negedge REF_CLK);
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'($urandom);
        chk("cg_off", 16'(CLK_GATE_EN), 16'd0);
        chk("tx_not_yet", 16'(TX_D_VLD), 16'd0);
        held = TX_P_DATA;
        if (bp) begin
            repeat (10) begin
                @(negedge REF_CLK);
                chk("bp_no_tx", 16'(TX_D_VLD), 16'd0);
                chk("bp_data_stable", 16'(TX_P_DATA), 16'(held));
            end
            FIFO_FULL = 1'b0;
        end
        @(negedge REF_CLK);
        chk("tx_lo_vld", 16'(TX_D_VLD), 16'd1);
        chk("tx_lo_data", 16'(TX_P_DATA), 16'(exp[7:0]));
        @(negedge REF_CLK);
        chk("tx_hi_vld", 16'(TX_D_VLD), 16'd1);
        chk("tx_hi_data", 16'(TX_P_DATA), 16'(exp[15:8]));
        @(negedge REF_CLK);
        chk("tx_done", 16'(TX_D_VLD), 16'd0);
    endtask

    task automatic junk(input logic [7:0] j);
        send(j);
        chk_quiet("junk_quiet");
        chk("junk_cg", 16'(CLK_GATE_EN), 16'd0);
        idle(2);
        chk_quiet("junk_still_quiet");
    endtask

    initial begin
        logic [7:0] j;
        int         k;
        #2 RST_N = 1'b0;
        #1 chk_reset("reset0");
        repeat (2) @(negedge REF_CLK);
        chk_reset("reset0_held");
        RST_N = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'($urandom);
            env_mem[i] = ref_mem[i];
        end
        @(negedge REF_CLK);

        wr_frame(8'h0A, 8'h05, 0);
        rd_frame(8'h0A, 0, 0, 1'b0);
        alu_frame(1'b1, 8'h0A, 8'h0C, 8'h00, 0, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
        alu_frame(1'b0, 8'h00, 8'h00, 8'h06, 0, 2, 1'b0, 1'b0, 1'b1, 16'hFFF7);
        alu_frame(1'b0, 8'h00, 8'h00, 8'h00, 1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);
        junk(8'h55);
        rd_frame(8'h03, 1, 2, 1'b0);
        alu_frame(1'b0, 8'h00, 8'h00, 8'h01, 0, 3, 1'b0, 1'b1, 1'b0, 16'h0000);
        rd_frame(8'hF7, 0, 1, 1'b1);
        wr_frame(8'h02, 8'h3C, 0);

        send(8'hAA);
        send(8'h0A);
        RST_N = 1'b0;
        #1 chk_reset("reset_mid");
        @(negedge REF_CLK);
        RST_N = 1'b1;
        wr_frame(8'h04, 8'h07, 0);
        rd_frame(8'h0A, 0, 0, 1'b0);
        rd_frame(8'h04, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 4));
            case (k)
                0: wr_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
                1: rd_frame(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
                2, 3: alu_frame(k == 2, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                                int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, 1'($urandom),
                                1'b0, 16'h0000);
                default: begin
                    j = 8'($urandom);
                    if (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) j = 8'h00;
                    junk(j);
                end
            endcase
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
